// File: rtl/fp16_pkg.sv
// Shared IEEE-754 binary16 field widths and special encodings used by the
// fixed<->fp16 converters of the accelerator write-back path.
package fp16_pkg;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP16_BIAS  = 15;

  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
  localparam logic [15:0] FP16_ZERO    = 16'h0000;

endpackage

// File: rtl/lzc.sv
// Combinational leading-zero counter with an all-zero flag.
// count is only meaningful when zero is low.
module lzc #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count,
  output logic             zero
);

  // Scan upward so the highest set bit is the last one to write count.
  always_comb begin
    count = '0;
    zero  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) begin
        count = CW'(WIDTH - 1 - i);
        zero  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fixed_to_fp16_pipe.sv
// Three-stage valid/ready converter from signed fixed point to fp16 with
// round-to-nearest-even, flush-to-zero below the normal range and saturation.
module fixed_to_fp16_pipe
  import fp16_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         out_data
);

  localparam int PW      = $clog2(IN_WIDTH);
  localparam int FW      = IN_WIDTH - 1;
  localparam int MAN_LSB = FW - FP16_MAN_W;
  localparam int EXP_MAX = (1 << FP16_EXP_W) - 1;

  logic                s1_valid;
  logic                s1_sign;
  logic [IN_WIDTH-1:0] s1_mag;

  logic                s2_valid;
  logic                s2_sign;
  logic                s2_zero;
  logic [PW-1:0]       s2_p;
  logic [FW-1:0]       s2_frac;

  logic                s1_load;
  logic                s2_load;
  logic                s3_load;

  logic [PW-1:0]       lz;
  logic                all_zero;

  logic [FP16_MAN_W-1:0] man;
  logic                  guard;
  logic                  sticky;
  logic                  round_up;
  logic [FP16_MAN_W:0]   man_sum;
  int                    exp_pre;
  int                    exp_post;
  logic [15:0]           result;

  assign s3_load  = !out_valid || out_ready;
  assign s2_load  = !s2_valid || s3_load;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Negating the most-negative input wraps back to 2^(IN_WIDTH-1), which is
  // the correct unsigned magnitude.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      s1_sign  <= in_data[IN_WIDTH-1];
      s1_mag   <= in_data[IN_WIDTH-1] ? -in_data : in_data;
    end
  end

  lzc #(.WIDTH(IN_WIDTH), .CW(PW)) u_lzc (
    .data  (s1_mag),
    .count (lz),
    .zero  (all_zero)
  );

  // The leading one is implicit after normalisation, so only the bits below it are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b1;
      s2_p     <= '0;
      s2_frac  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= all_zero;
      s2_p     <= PW'(IN_WIDTH - 1) - lz;
      s2_frac  <= FW'(s1_mag << lz);
    end
  end

  always_comb begin
    man      = s2_frac[FW-1 -: FP16_MAN_W];
    guard    = s2_frac[MAN_LSB-1];
    sticky   = |s2_frac[MAN_LSB-2:0];
    round_up = guard && (sticky || man[0]);
    man_sum  = {1'b0, man} + {{FP16_MAN_W{1'b0}}, round_up};
    exp_pre  = int'(s2_p) - FRAC_BITS + FP16_BIAS;
    exp_post = exp_pre + int'(man_sum[FP16_MAN_W]);
    result   = FP16_ZERO;
    // Flushing uses the pre-rounding exponent, so no subnormal ever rounds up into range.
    if (s2_zero) begin
      result = FP16_ZERO;
    end else if (exp_pre <= 0) begin
      result = {s2_sign, {(FP16_EXP_W + FP16_MAN_W){1'b0}}};
    end else if (exp_post >= EXP_MAX) begin
      result = s2_sign ? FP16_NEG_INF : FP16_POS_INF;
    end else begin
      result = {s2_sign, exp_post[FP16_EXP_W-1:0], man_sum[FP16_MAN_W-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= FP16_ZERO;
    end else if (s3_load) begin
      out_valid <= s2_valid;
      out_data  <= result;
    end
  end

endmodule

// File: tb/tb_fixed_to_fp16_pipe.sv
// Self-checking bench for fixed_to_fp16_pipe: directed cases, backpressure,
// randomized handshakes against an arithmetic RNE model, and mid-stream reset.
module tb_fixed_to_fp16_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  fixed_to_fp16_pipe #(.IN_WIDTH(32), .FRAC_BITS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value = in_data / 2^16, rounded to 11 significant bits by
  // integer division with ties to even.
  function automatic logic [15:0] ref_fp16(input logic [31:0] x);
    longint v, mag, dv, q, rem, half;
    int     e, bexp;
    logic   sgn;
    v   = longint'($signed(x));
    sgn = (v < 0);
    mag = sgn ? -v : v;
    if (mag == 0) return 16'h0000;
    e = 0;
    while ((longint'(1) << (e + 1)) <= mag) e++;
    bexp = e - 16 + 15;
    if (bexp <= 0) return {sgn, 15'h0000};
    if (e <= 10) begin
      q = mag << (10 - e);
    end else begin
      dv   = longint'(1) << (e - 10);
      q    = mag / dv;
      rem  = mag % dv;
      half = dv / 2;
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end
    if (q == 2048) begin
      q    = 1024;
      bexp = bexp + 1;
    end
    if (bexp >= 31) return sgn ? 16'hFC00 : 16'h7C00;
    return {sgn, 5'(bexp), 10'(q)};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    logic [31:0] specials [4];
    specials[0] = 32'h8000_0000;
    specials[1] = 32'h7FFF_FFFF;
    specials[2] = 32'h0000_0000;
    specials[3] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 15) == 0) return specials[$urandom_range(0, 3)];
    r = $urandom;
    r = r >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) r = -r;
    return r;
  endfunction

  task automatic test_reset();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_out_data: got %h expected 0000", out_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vin  [11];
    logic [15:0] vexp [11];
    int cyc;
    vin[0]  = 32'h0001_0000; vexp[0]  = 16'h3C00;
    vin[1]  = 32'hFFFF_8000; vexp[1]  = 16'hB800;
    vin[2]  = 32'h0000_0000; vexp[2]  = 16'h0000;
    vin[3]  = 32'h0001_0020; vexp[3]  = 16'h3C00;
    vin[4]  = 32'h0001_0060; vexp[4]  = 16'h3C02;
    vin[5]  = 32'h0001_0021; vexp[5]  = 16'h3C01;
    vin[6]  = 32'h7FFF_FFFF; vexp[6]  = 16'h7800;
    vin[7]  = 32'h8000_0000; vexp[7]  = 16'hF800;
    vin[8]  = 32'h0000_0004; vexp[8]  = 16'h0400;
    vin[9]  = 32'h0000_0001; vexp[9]  = 16'h0000;
    vin[10] = 32'hFFFF_FFFF; vexp[10] = 16'h8000;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = vin[i];
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (cyc !== 3) begin
        errors++;
        $display("[TB] FAIL latency_%0d: got %0d cycles expected 3", i, cyc);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== vexp[i]) begin
        errors++;
        $display("[TB] FAIL directed_%0d in=%h: got valid=%b data=%h expected %h",
                 i, vin[i], out_valid, out_data, vexp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [6];
    logic [15:0] held;
    int idx, got, gaps, cyc;
    for (int i = 0; i < 6; i++) w[i] = rand_word();
    exp_q.delete();
    idx = 0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      in_valid = 1'b1;
      in_data  = w[idx];
      #1;
      if (in_ready) begin
        exp_q.push_back(ref_fp16(w[idx]));
        idx++;
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (idx !== 3) begin
      errors++;
      $display("[TB] FAIL bp_accepted: got %0d expected 3", idx);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_in_ready: got %b expected 0", in_ready);
    end
    held = out_data;
    checks++;
    if (out_valid !== 1'b1 || held !== exp_q[0]) begin
      errors++;
      $display("[TB] FAIL bp_head: got valid=%b data=%h expected %h", out_valid, held, exp_q[0]);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d: got valid=%b data=%h expected %h", c, out_valid, out_data, held);
      end
    end
    got = 0;
    gaps = 0;
    cyc = 0;
    while (got < 6 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'b1;
      in_valid  = (idx < 6);
      in_data   = (idx < 6) ? w[idx] : 32'h0;
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL bp_extra: got %h expected nothing", out_data);
        end else if (out_data !== exp_q[0]) begin
          errors++;
          $display("[TB] FAIL bp_order_%0d: got %h expected %h", got, out_data, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
        got++;
      end else begin
        gaps++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_fp16(w[idx]));
        idx++;
      end
    end
    checks++;
    if (got !== 6 || gaps !== 0 || idx !== 6) begin
      errors++;
      $display("[TB] FAIL bp_drain: got %0d outputs %0d gaps %0d accepted expected 6 0 6", got, gaps, idx);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_duplicate: got valid=%b data=%h expected idle", out_valid, out_data);
    end
  endtask

  task automatic test_random();
    int acc, cyc, pops;
    logic prev_stall;
    logic [15:0] prev_data;
    exp_q.delete();
    acc = 0;
    cyc = 0;
    pops = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    while ((acc < 10000 || exp_q.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (acc < 10000) && ($urandom_range(0, 9) < 7);
      in_data   = rand_word();
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++;
          $display("[TB] FAIL rand_stable: got valid=%b data=%h expected 1 %h", out_valid, out_data, prev_data);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL rand_extra: got %h expected nothing", out_data);
        end else begin
          if (out_data !== exp_q[0]) begin
            errors++;
            $display("[TB] FAIL rand_out_%0d: got %h expected %h", pops, out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
          pops++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_fp16(in_data));
        acc++;
      end
    end
    checks++;
    if (acc !== 10000 || exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL rand_complete: got %0d accepted %0d pending expected 10000 0", acc, exp_q.size());
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    logic [31:0] w;
    int acc, cyc;
    acc = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h0002_0000 + 32'(i);
      #1;
      if (in_ready) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (acc !== 3 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_inflight: got %0d accepted valid=%b expected 3 1", acc, out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL mid_reset_out: got valid=%b data=%h expected 0 0000", out_valid, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    w = 32'hFFFE_C000;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = w;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("[TB] FAIL mid_latency: got %0d cycles expected 3", cyc);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== ref_fp16(w)) begin
      errors++;
      $display("[TB] FAIL mid_first_word: got valid=%b data=%h expected %h", out_valid, out_data, ref_fp16(w));
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_stale: got valid=%b data=%h expected idle", out_valid, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
